conv3x3_stream_ctrl: RTL and testbench

- Sequencer for the 3x3 convolutor/max-pool datapath: walks one image channel out of pixel memory and streams it into the convolutor's pixel input one pixel per clock.
- Inserts top and bottom zero padding and drives the convolutor's left/right padding masks.
- Tags each convolutor result with out_valid and its output row/column; pulses done at end of frame.
- Sits between the layer scheduler (start/config) and the convolutor plus its result writer.

---
 rtl/conv3x3_stream_ctrl_pkg.sv | 29 ++
 rtl/conv3x3_stream_ctrl_if.sv | 34 +++
 rtl/conv3x3_stream_ctrl_tag_delay_line.sv | 35 +++
 rtl/conv3x3_stream_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_conv3x3_stream_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv3x3_stream_ctrl_pkg.sv
// Shared definitions for the 3x3 conv / 2x2 maxpool stream sequencer.
// Includes the operation encodings, FSM states, the result tag layout and default latencies.
package conv3x3_stream_ctrl_pkg;

  localparam logic [1:0] OP_CONV3X3    = 2'd0;
  localparam logic [1:0] OP_MAXPOOL2X2 = 2'd1;

  localparam int unsigned MEM_LAT_DEF     = 1;
  localparam int unsigned COLLECT_LAT_DEF = 1;

  typedef enum logic [2:0] {
    StIdle,
    StPadTop,
    StBody,
    StPadBot,
    StDrain,
    StFin
  } state_e;

  // Per-result side information that travels alongside the datapath.
  typedef struct packed {
    logic       valid;
    logic [7:0] row;
    logic [7:0] col;
    logic       padl;
    logic       padr;
  } tag_t;

endpackage

// File: rtl/conv3x3_stream_ctrl_if.sv
// Bundle of scheduler config, pixel-memory read port and convolutor-facing signals.
// The master modport is the sequencer's view; the slave modport is the surrounding system.
interface conv3x3_stream_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic [1:0]        op_in;
  logic [7:0]        width;
  logic [7:0]        height;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [7:0]        mem_rdata;
  logic [7:0]        pixel_in;
  logic [1:0]        operation;
  logic              paddingl;
  logic              paddingr;
  logic              out_valid;
  logic [7:0]        out_row;
  logic [7:0]        out_col;
  logic              busy;
  logic              done;

  modport master (
    input  start, op_in, width, height, base_addr, mem_rdata,
    output mem_raddr, pixel_in, operation, paddingl, paddingr,
           out_valid, out_row, out_col, busy, done
  );

  modport slave (
    output start, op_in, width, height, base_addr, mem_rdata,
    input  mem_raddr, pixel_in, operation, paddingl, paddingr,
           out_valid, out_row, out_col, busy, done
  );
endinterface

// File: rtl/conv3x3_stream_ctrl_tag_delay_line.sv
// Fixed-depth shift register that aligns result tags with the convolutor output.
module conv3x3_stream_ctrl_tag_delay_line
  import conv3x3_stream_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [Depth];
  tag_t pipe_d [Depth];

  always_comb begin
    pipe_d[0] = tag_i;
    for (int i = 1; i < int'(Depth); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[Depth-1];

endmodule

// File: rtl/conv3x3_stream_ctrl.sv
// Streams one image channel (with top/bottom zero rows) into the 3x3 convolutor and tags
// each convolutor result with validity, output coordinates and left/right padding masks.
module conv3x3_stream_ctrl
  import conv3x3_stream_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MEM_LAT     = MEM_LAT_DEF,
  parameter int unsigned COLLECT_LAT = COLLECT_LAT_DEF
) (
  input logic                   clk,
  input logic                   rst,
  conv3x3_stream_ctrl_if.master bus
);

  localparam int unsigned Lat = MEM_LAT + COLLECT_LAT;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [7:0]          w_q, w_d, h_q, h_d;
  logic [7:0]          row_q, row_d, col_q, col_d;
  logic [7:0]          cen_row_q, cen_row_d, cen_col_q, cen_col_d;
  logic                cen_v_q, cen_v_d;
  logic [7:0]          drain_q, drain_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [MEM_LAT-1:0]  rd_pipe_q, rd_pipe_d;
  logic                rd_en;
  logic                last_col;
  tag_t                tag_live, tag_out;

  assign last_col = (col_q == w_q - 8'd1);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    w_d       = w_q;
    h_d       = h_q;
    row_d     = row_q;
    col_d     = col_q;
    cen_row_d = cen_row_q;
    cen_col_d = cen_col_q;
    cen_v_d   = cen_v_q;
    drain_d   = drain_q;
    ptr_d     = ptr_q;
    rd_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d    = bus.op_in;
          w_d     = bus.width;
          h_d     = bus.height;
          ptr_d   = bus.base_addr;
          row_d   = 8'd0;
          col_d   = 8'd0;
          cen_v_d = 1'b0;
          state_d = (bus.width == 8'd0 || bus.height == 8'd0) ? StFin : StPadTop;
        end
      end
      StPadTop: begin
        if (last_col) begin
          col_d   = 8'd0;
          state_d = StBody;
        end else begin
          col_d = col_q + 8'd1;
        end
      end
      StBody: begin
        rd_en     = 1'b1;
        ptr_d     = ptr_q + 1'b1;
        // The window centre trails the newest streamed pixel by one position.
        cen_v_d   = 1'b1;
        cen_row_d = row_q;
        cen_col_d = col_q;
        if (last_col) begin
          col_d = 8'd0;
          if (row_q == h_q - 8'd1) begin
            row_d   = 8'd0;
            state_d = StPadBot;
          end else begin
            row_d = row_q + 8'd1;
          end
        end else begin
          col_d = col_q + 8'd1;
        end
      end
      StPadBot: begin
        drain_d = 8'd0;
        state_d = StDrain;
      end
      StDrain: begin
        if (drain_q == 8'(Lat - 1)) begin
          state_d = StFin;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    tag_live = '0;
    if ((state_q == StBody || state_q == StPadBot) && cen_v_q) begin
      if (op_q == OP_CONV3X3) begin
        tag_live.valid = 1'b1;
        tag_live.row   = cen_row_q;
        tag_live.col   = cen_col_q;
        tag_live.padl  = (cen_col_q == 8'd0);
        tag_live.padr  = (cen_col_q == w_q - 8'd1);
      end else if (op_q == OP_MAXPOOL2X2) begin
        // A 2x2 block completes at an odd/odd centre; odd trailing row/col never qualifies.
        if (cen_row_q[0] && cen_col_q[0]) begin
          tag_live.valid = 1'b1;
          tag_live.row   = {1'b0, cen_row_q[7:1]};
          tag_live.col   = {1'b0, cen_col_q[7:1]};
        end
      end
    end
  end

  always_comb begin
    rd_pipe_d[0] = rd_en;
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= 2'd0;
      w_q       <= 8'd0;
      h_q       <= 8'd0;
      row_q     <= 8'd0;
      col_q     <= 8'd0;
      cen_row_q <= 8'd0;
      cen_col_q <= 8'd0;
      cen_v_q   <= 1'b0;
      drain_q   <= 8'd0;
      ptr_q     <= '0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      w_q       <= w_d;
      h_q       <= h_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cen_row_q <= cen_row_d;
      cen_col_q <= cen_col_d;
      cen_v_q   <= cen_v_d;
      drain_q   <= drain_d;
      ptr_q     <= ptr_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  conv3x3_stream_ctrl_tag_delay_line #(
    .Depth (Lat)
  ) u_tag_delay (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_live),
    .tag_o (tag_out)
  );

  assign bus.mem_raddr = rd_en ? ptr_q : '0;
  assign bus.pixel_in  = rd_pipe_q[MEM_LAT-1] ? bus.mem_rdata : 8'd0;
  assign bus.operation = op_q;
  assign bus.out_valid = tag_out.valid;
  assign bus.out_row   = tag_out.row;
  assign bus.out_col   = tag_out.col;
  assign bus.paddingl  = tag_out.padl;
  assign bus.paddingr  = tag_out.padr;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StFin);

endmodule

// File: tb/tb_conv3x3_stream_ctrl.sv
// Directed bench: records the pixel stream and result tags, rebuilds convolutor/maxpool
// results from the captured stream and compares against hand-computed values.
module tb_conv3x3_stream_ctrl;

  localparam int unsigned MEM_LAT     = 1;
  localparam int unsigned COLLECT_LAT = 1;
  localparam logic [15:0] BASE        = 16'h0040;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv3x3_stream_ctrl_if #(.ADDR_W(16)) bus ();

  conv3x3_stream_ctrl #(
    .ADDR_W      (16),
    .MEM_LAT     (MEM_LAT),
    .COLLECT_LAT (COLLECT_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:1023];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_raddr[9:0]];

  int n_cmp = 0;
  int n_fail = 0;

  int cyc, tcyc, rd_cnt, valid_cnt, done_cnt, last_valid_t, done_t;
  int stream [0:1023];
  int q_row[$], q_col[$], q_pl[$], q_pr[$];

  always @(negedge clk) begin
    if (bus.busy) begin
      if (cyc >= int'(MEM_LAT) && cyc - int'(MEM_LAT) < 1024)
        stream[cyc - int'(MEM_LAT)] = int'(bus.pixel_in);
      cyc++;
    end
    if (bus.mem_raddr != 16'd0) rd_cnt++;
    if (bus.out_valid) begin
      valid_cnt++;
      last_valid_t = tcyc;
      q_row.push_back(int'(bus.out_row));
      q_col.push_back(int'(bus.out_col));
      q_pl.push_back(int'(bus.paddingl));
      q_pr.push_back(int'(bus.paddingr));
    end
    if (bus.done) begin
      if (done_cnt == 0) done_t = tcyc;
      done_cnt++;
    end
    tcyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int which, input int i);
    case (which)
      0: return (i < q_row.size()) ? q_row[i] : -1;
      1: return (i < q_col.size()) ? q_col[i] : -1;
      2: return (i < q_pl.size()) ? q_pl[i] : -1;
      default: return (i < q_pr.size()) ? q_pr[i] : -1;
    endcase
  endfunction

  // Streaming 3x3 sum over the captured stream, with the column masks applied.
  function automatic int conv_model(input int i, input int w, input int h);
    int s = 0;
    int r = qget(0, i);
    int c = qget(1, i);
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int li;
        li = (r + dr) * w + c + dc;
        if ((dc == -1 && qget(2, i) != 0) || (dc == 1 && qget(3, i) != 0)) continue;
        if (li >= 0 && li < h * w) s += stream[w + li];
      end
    end
    return s;
  endfunction

  function automatic int pool_model(input int i, input int w);
    int m = -1;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        if (stream[w + (2 * qget(0, i) + a) * w + 2 * qget(1, i) + b] > m)
          m = stream[w + (2 * qget(0, i) + a) * w + 2 * qget(1, i) + b];
    return m;
  endfunction

  function automatic int pad_nonzero(input int w, input int h);
    int n = 0;
    for (int s = 0; s < w; s++) if (stream[s] != 0) n++;
    if (stream[w + h * w] != 0) n++;
    return n;
  endfunction

  task automatic fill_mem(input int kind, input int val);
    for (int i = 0; i < 1024; i++) mem[i] = 8'hA5;
    for (int i = 0; i < 64; i++) begin
      if (kind == 0) mem[int'(BASE) + i] = 8'(val);
      else if (kind == 1) mem[int'(BASE) + i] = 8'(int'(BASE) + i);
      else mem[int'(BASE) + i] = 8'(i);
    end
  endtask

  task automatic clear_mon();
    cyc = 0; rd_cnt = 0; valid_cnt = 0; done_cnt = 0; last_valid_t = -1; done_t = -1;
    for (int i = 0; i < 1024; i++) stream[i] = -1;
    q_row.delete(); q_col.delete(); q_pl.delete(); q_pr.delete();
  endtask

  task automatic run_frame(input logic [1:0] op, input int w, input int h, input int glitch,
                           input bit fin_start, output int lat);
    bit got = 0;
    clear_mon();
    lat = -1;
    bus.op_in = op; bus.width = 8'(w); bus.height = 8'(h); bus.base_addr = BASE;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (bus.done === 1'b1) begin
        got = 1;
        lat = i;
        if (fin_start) begin
          bus.start = 1'b1;
          @(posedge clk); #1;
          bus.start = 1'b0;
          check("fin_start_ignored", 32'(bus.busy), 0);
        end
      end else begin
        if (i == glitch) begin
          bus.start = 1'b1; bus.width = 8'd2; bus.op_in = 2'd0;
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.width = 8'(w); bus.op_in = op;
      end
    end
    check("done_seen", 32'(got), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  int lat;
  int exp1 [12] = '{4, 6, 6, 4, 6, 9, 9, 6, 4, 6, 6, 4};
  int exp4 [9]  = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
  int exp3 [4]  = '{5, 7, 13, 15};
  int exp6 [3]  = '{4, 6, 4};

  initial begin
    bus.start = 1'b0; bus.op_in = 2'd0; bus.width = 8'd0; bus.height = 8'd0;
    bus.base_addr = BASE;
    fill_mem(0, 1);
    clear_mon();
    tcyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_raddr", 32'(bus.mem_raddr), 0);
    check("rst_outputs", 32'({bus.pixel_in, bus.operation, bus.paddingl, bus.paddingr,
                              bus.out_valid, bus.out_row, bus.out_col, bus.busy, bus.done}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Conv 4x3, all ones
    fill_mem(0, 1);
    run_frame(2'd0, 4, 3, -1, 1'b0, lat);
    check("c43_count", 32'(valid_cnt), 12);
    for (int i = 0; i < 12; i++) begin
      check("c43_sum", 32'(conv_model(i, 4, 3)), 32'(exp1[i]));
      check("c43_row", 32'(qget(0, i)), 32'(i / 4));
      check("c43_col", 32'(qget(1, i)), 32'(i % 4));
    end
    check("c43_done_lat", 32'(lat), 19);
    check("c43_done_after_valid", 32'(done_t), 32'(last_valid_t + 1));
    check("c43_done_cnt", 32'(done_cnt), 1);
    check("c43_reads", 32'(rd_cnt), 12);
    check("c43_pad_zero", 32'(pad_nonzero(4, 3)), 0);

    // Conv 5x2, pixel = address
    fill_mem(1, 0);
    run_frame(2'd0, 5, 2, -1, 1'b0, lat);
    check("c52_count", 32'(valid_cnt), 10);
    for (int i = 0; i < 10; i++) begin
      check("c52_row", 32'(qget(0, i)), 32'(i / 5));
      check("c52_col", 32'(qget(1, i)), 32'(i % 5));
      check("c52_padl", 32'(qget(2, i)), (i % 5 == 0) ? 1 : 0);
      check("c52_padr", 32'(qget(3, i)), (i % 5 == 4) ? 1 : 0);
    end
    check("c52_sum_first", 32'(conv_model(0, 5, 2)), 268);
    check("c52_sum_last", 32'(conv_model(9, 5, 2)), 280);

    // Maxpool 4x4, pixel = row*4+col, with a start pulse mid-frame
    fill_mem(2, 0);
    run_frame(2'd1, 4, 4, 5, 1'b0, lat);
    check("mp_count", 32'(valid_cnt), 4);
    for (int i = 0; i < 4; i++) begin
      check("mp_val", 32'(pool_model(i, 4)), 32'(exp3[i]));
      check("mp_row", 32'(qget(0, i)), 32'(i / 2));
      check("mp_col", 32'(qget(1, i)), 32'(i % 2));
      check("mp_pads", 32'(qget(2, i) + qget(3, i)), 0);
    end
    check("mp_operation", 32'(bus.operation), 1);
    check("mp_done_cnt", 32'(done_cnt), 1);

    // Reset while in BODY, then a clean 3x3 frame
    fill_mem(0, 1);
    bus.op_in = 2'd0; bus.width = 8'd4; bus.height = 8'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_raddr", 32'(bus.mem_raddr), 0);
    check("abort_outputs", 32'({bus.pixel_in, bus.operation, bus.paddingl, bus.paddingr,
                                bus.out_valid, bus.out_row, bus.out_col, bus.busy, bus.done}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(2'd0, 3, 3, -1, 1'b0, lat);
    check("r33_count", 32'(valid_cnt), 9);
    for (int i = 0; i < 9; i++)
      check("r33_sum", 32'(conv_model(i, 3, 3)), 32'(exp4[i]));
    check("r33_done_cnt", 32'(done_cnt), 1);
    check("r33_done_lat", 32'(lat), 15);

    // Degenerate width
    run_frame(2'd0, 0, 3, -1, 1'b0, lat);
    check("w0_done_lat", 32'(lat), 0);
    check("w0_done_cnt", 32'(done_cnt), 1);
    check("w0_valid", 32'(valid_cnt), 0);
    check("w0_reads", 32'(rd_cnt), 0);

    // Reserved operation code
    run_frame(2'd2, 2, 2, -1, 1'b0, lat);
    check("op2_valid", 32'(valid_cnt), 0);
    check("op2_done_cnt", 32'(done_cnt), 1);
    check("op2_reads", 32'(rd_cnt), 4);

    // Single-column image, start offered during FIN
    fill_mem(0, 2);
    run_frame(2'd0, 1, 3, -1, 1'b1, lat);
    check("w1_count", 32'(valid_cnt), 3);
    for (int i = 0; i < 3; i++) begin
      check("w1_sum", 32'(conv_model(i, 1, 3)), 32'(exp6[i]));
      check("w1_padl", 32'(qget(2, i)), 1);
      check("w1_padr", 32'(qget(3, i)), 1);
    end
    check("w1_done_lat", 32'(lat), 7);
    check("w1_done_cnt", 32'(done_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
